// File: rtl/reg_serializer.sv
// rtl/reg_serializer.sv - parallel word to 1-bit valid/ready stream serializer
// Optional trailing even-parity bit enabled by defining REG_SERIALIZER_PARITY_EN.
module reg_serializer #(
    parameter int DATAWIDTH = 64,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] d,
    input  logic                 d_valid,
    output logic                 d_ready,
    output logic                 sout,
    output logic                 sout_valid,
    input  logic                 sout_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

`ifdef REG_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    logic parity;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t               state;
    logic [DATAWIDTH-1:0] sreg;
    logic [CW-1:0]        cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
`ifdef REG_SERIALIZER_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_valid) begin
                        sreg  <= d;
                        cnt   <= '0;
                        state <= SHIFT;
`ifdef REG_SERIALIZER_PARITY_EN
                        parity <= ^d;
`endif
                    end
                end
                SHIFT: begin
                    // Everything holds while the sink stalls, so no bit is lost or repeated.
                    if (sout_ready) begin
                        sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
                        cnt  <= cnt + CW'(1);
                        if (cnt == LAST) begin
`ifdef REG_SERIALIZER_PARITY_EN
                            state <= PAR;
`else
                            state <= IDLE;
                            done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef REG_SERIALIZER_PARITY_EN
                PAR: begin
                    if (sout_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign d_ready    = (state == IDLE);
    assign sout_valid = (state != IDLE);
    assign busy       = (state != IDLE);

    always_comb begin
        sout = 1'b0;
        case (state)
            SHIFT: sout = MSB_FIRST ? sreg[DATAWIDTH-1] : sreg[0];
`ifdef REG_SERIALIZER_PARITY_EN
            PAR:   sout = parity;
`endif
            default: sout = 1'b0;
        endcase
    end

endmodule
